// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between the IF fetch port and the MEM load/store port:
// DM-first arbitration with an IF anti-starvation limit, transaction sequencing and a response timeout.
module mem_arbiter #(
    parameter int unsigned MAX_DM_STREAK = 2,
    parameter int unsigned TIMEOUT       = 16,
    parameter int unsigned CNT_W         = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    output logic [1:0]  owner,
    output logic        timeout_err
);

    localparam int unsigned         STREAK_W   = $clog2(MAX_DM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);
    localparam logic [CNT_W-1:0]    TCNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } state_e;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

    state_e              state_q;
    logic [STREAK_W-1:0] streak_q;
    logic [CNT_W-1:0]    tcnt_q;
    logic                if_valid_q;
    logic                dm_valid_q;
    logic [31:0]         if_rdata_q;
    logic [31:0]         dm_rdata_q;
    logic                ram_en_q;
    logic                ram_we_q;
    logic [31:0]         ram_addr_q;
    logic [31:0]         ram_wdata_q;
    logic [1:0]          owner_q;
    logic                timeout_err_q;

    logic dm_wins;
    logic done;

    // DM has priority unless IF has already been passed over MAX_DM_STREAK times in a row.
    assign dm_wins = dm_req && !(if_req && (streak_q == STREAK_MAX));
    assign done    = ram_ready || (tcnt_q == TCNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: every output register is cleared here, data paths included, so an
            // abandoned transaction leaves nothing visible after reset.
            state_q       <= IDLE;
            streak_q      <= '0;
            tcnt_q        <= '0;
            if_valid_q    <= 1'b0;
            dm_valid_q    <= 1'b0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            owner_q       <= OWN_NONE;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: the strobes default low each cycle; a later non-blocking assignment
            // in the same block overrides the default, which is what makes them one-cycle pulses.
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            ram_en_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (dm_wins) begin
                        state_q     <= WAIT_DM;
                        owner_q     <= OWN_DM;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= dm_we;
                        ram_addr_q  <= dm_addr;
                        ram_wdata_q <= dm_wdata;
                        tcnt_q      <= '0;
                        streak_q    <= if_req ? streak_q + STREAK_W'(1) : '0;
                    end else if (if_req) begin
                        state_q     <= WAIT_IF;
                        owner_q     <= OWN_IF;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= 1'b0;
                        ram_addr_q  <= if_addr;
                        ram_wdata_q <= '0;
                        tcnt_q      <= '0;
                        streak_q    <= '0;
                    end
                end

                WAIT_IF, WAIT_DM: begin
                    tcnt_q <= tcnt_q + CNT_W'(1);
                    if (done) begin
                        state_q <= IDLE;
                        owner_q <= OWN_NONE;
                        if (!ram_ready) begin
                            timeout_err_q <= 1'b1;
                        end
                        if (state_q == WAIT_IF) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= ram_ready ? ram_rdata : '0;
                        end else begin
                            dm_valid_q <= 1'b1;
                            dm_rdata_q <= (ram_ready && !ram_we_q) ? ram_rdata : '0;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_valid    = if_valid_q;
    assign dm_valid    = dm_valid_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;
    assign if_stall    = if_req & ~if_valid_q;
    assign dm_stall    = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios from the block's behaviour, then randomized
// requesters and RAM latency checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned MAX_DM_STREAK = 2;
    localparam int unsigned TIMEOUT       = 8;
    localparam int unsigned CNT_W         = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic [1:0]  owner;
    logic        timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem_m [logic [31:0]];

    mem_arbiter #(
        .MAX_DM_STREAK(MAX_DM_STREAK),
        .TIMEOUT      (TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_valid   (if_valid),
        .if_rdata   (if_rdata),
        .if_stall   (if_stall),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_valid   (dm_valid),
        .dm_rdata   (dm_rdata),
        .dm_stall   (dm_stall),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready),
        .owner      (owner),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_3C3C;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        ram_ready = 1'b0;
        ram_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [134:0] obs;
        reset     = 1'b1;
        if_req    = 1'b1;
        dm_req    = 1'b1;
        dm_we     = 1'b1;
        if_addr   = $urandom;
        dm_addr   = $urandom;
        dm_wdata  = $urandom;
        ram_ready = 1'b1;
        ram_rdata = $urandom;
        repeat (3) tick();
        obs = {ram_en, ram_we, ram_addr, ram_wdata, if_valid, dm_valid,
               if_rdata, dm_rdata, owner, timeout_err};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h expected 0", obs);
        end
        idle_inputs();
        #1;
        vectors++;
        if ({if_stall, dm_stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_stalls got %b expected 00", {if_stall, dm_stall});
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic [4:0] exp_ctl [6] = '{5'b0_00_0_1, 5'b1_01_0_1, 5'b0_01_0_1,
                                    5'b0_01_0_1, 5'b0_00_1_0, 5'b0_00_0_0};
        logic [4:0] obs;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            if_req    = (c < 4);
            if_addr   = 32'h4;
            ram_ready = (c == 3);
            ram_rdata = (c == 3) ? 32'h2008_0005 : 32'hFFFF_FFFF;
            #1;
            obs = {ram_en, owner, if_valid, if_stall};
            vectors++;
            if (obs !== exp_ctl[c]) begin
                miscompares++;
                $display("FAIL fetch_ctl cycle %0d got %b expected %b", c, obs, exp_ctl[c]);
            end
            if (c >= 1 && c <= 3) begin
                vectors++;
                if ({ram_we, ram_addr} !== {1'b0, 32'h4}) begin
                    miscompares++;
                    $display("FAIL fetch_ram cycle %0d got we=%b addr=%h expected we=0 addr=4",
                             c, ram_we, ram_addr);
                end
            end
            if (c == 4) begin
                vectors++;
                if (if_rdata !== 32'h2008_0005) begin
                    miscompares++;
                    $display("FAIL fetch_rdata got %h expected 20080005", if_rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        logic [6:0] exp_ctl [6] = '{7'b0_00_00_11, 7'b1_10_00_11, 7'b0_00_01_10,
                                    7'b1_01_00_10, 7'b0_00_10_00, 7'b0_00_00_00};
        logic [6:0] obs;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            if_req    = (c < 4);
            if_addr   = 32'h40;
            dm_req    = (c < 2);
            dm_we     = 1'b0;
            dm_addr   = 32'h100;
            ram_ready = 1'b1;
            ram_rdata = (ram_addr == 32'h100) ? 32'h1111_1111 : 32'h2222_2222;
            #1;
            obs = {ram_en, owner, if_valid, dm_valid, if_stall, dm_stall};
            vectors++;
            if (obs !== exp_ctl[c]) begin
                miscompares++;
                $display("FAIL collide_ctl cycle %0d got %b expected %b", c, obs, exp_ctl[c]);
            end
            if (c == 1 || c == 3) begin
                vectors++;
                if (ram_addr !== ((c == 1) ? 32'h100 : 32'h40)) begin
                    miscompares++;
                    $display("FAIL collide_addr cycle %0d got %h", c, ram_addr);
                end
            end
            if (c == 2 || c == 4) begin
                vectors++;
                if ((c == 2 ? dm_rdata : if_rdata) !== (c == 2 ? 32'h1111_1111 : 32'h2222_2222)) begin
                    miscompares++;
                    $display("FAIL collide_rdata cycle %0d got dm=%h if=%h", c, dm_rdata, if_rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [1:0] seq [6] = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1};
        logic [4:0] obs;
        logic [4:0] expv;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c > 0) tick();
            if_req    = 1'b1;
            if_addr   = 32'h400;
            dm_req    = 1'b1;
            dm_we     = 1'b0;
            dm_addr   = 32'h500;
            ram_ready = 1'b1;
            ram_rdata = $urandom;
            #1;
            if (c == 0)          expv = 5'b0_00_00;
            else if (c % 2 == 1) expv = {1'b1, seq[(c - 1) / 2], 2'b00};
            else                 expv = {3'b0_00, seq[(c - 2) / 2] == 2'd1, seq[(c - 2) / 2] == 2'd2};
            obs = {ram_en, owner, if_valid, dm_valid};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL starve_ctl cycle %0d got %b expected %b", c, obs, expv);
            end
        end
        idle_inputs();
    endtask

    task automatic test_store();
        do_reset();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h10;
        dm_wdata = 32'hDEAD_BEEF;
        tick();
        dm_req    = 1'b0;
        ram_ready = 1'b1;
        ram_rdata = 32'hBADC_0FFE;
        #1;
        vectors++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, owner, dm_stall} !==
            {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL store_ram got en=%b we=%b addr=%h wdata=%h owner=%0d expected 1 1 10 deadbeef 2",
                     ram_en, ram_we, ram_addr, ram_wdata, owner);
        end
        tick();
        ram_ready = 1'b0;
        #1;
        vectors++;
        if ({dm_valid, dm_rdata} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL store_done got valid=%b rdata=%h expected 1 0", dm_valid, dm_rdata);
        end
        tick();
        vectors++;
        if (dm_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL store_pulse got valid=%b expected 0", dm_valid);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic [2:0] obs;
        logic [2:0] expv;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c > 0) tick();
            dm_req    = (c < 9);
            dm_we     = 1'b0;
            dm_addr   = 32'h200;
            if_req    = (c >= 10 && c < 12);
            if_addr   = 32'h20;
            ram_ready = (c >= 10);
            ram_rdata = (c < 10) ? 32'hCAFE_F00D : 32'h0000_0077;
            #1;
            if (c >= 1) begin
                obs  = {dm_valid, if_valid, timeout_err};
                expv = {c == 9, c == 12, c >= 9};
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL timeout_ctl cycle %0d got %b expected %b", c, obs, expv);
                end
            end
            if (c >= 1 && c <= 9) begin
                vectors++;
                if (ram_addr !== 32'h200) begin
                    miscompares++;
                    $display("FAIL timeout_addr cycle %0d got %h expected 200", c, ram_addr);
                end
            end
            if (c == 9 || c == 12) begin
                vectors++;
                if ((c == 9 ? dm_rdata : if_rdata) !== (c == 9 ? 32'h0 : 32'h77)) begin
                    miscompares++;
                    $display("FAIL timeout_rdata cycle %0d got dm=%h if=%h", c, dm_rdata, if_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [134:0] obs;
        if_req    = 1'b1;
        if_addr   = 32'h8;
        dm_req    = 1'b0;
        ram_ready = 1'b0;
        #1;
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL sticky_err got %b expected 1", timeout_err);
        end
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if ({ram_en, owner} !== 3'b1_01) begin
            miscompares++;
            $display("FAIL midreset_grant got %b expected 101", {ram_en, owner});
        end
        tick();
        reset     = 1'b0;
        if_req    = 1'b0;
        ram_ready = 1'b1;
        ram_rdata = 32'h5555_AAAA;
        #1;
        obs = {ram_en, ram_we, ram_addr, ram_wdata, if_valid, dm_valid,
               if_rdata, dm_rdata, owner, timeout_err};
        vectors++;
        if (obs !== '0 || if_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs got %h stall=%b expected 0", obs, if_stall);
        end
        tick();
        if_req    = 1'b1;
        if_addr   = 32'hC;
        ram_rdata = 32'h0BAD_F00D;
        #1;
        obs = {ram_en, ram_we, ram_addr, ram_wdata, if_valid, dm_valid,
               if_rdata, dm_rdata, owner, timeout_err};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL late_ready got %h expected 0", obs);
        end
        tick();
        vectors++;
        if ({ram_en, owner, ram_addr} !== {1'b1, 2'd1, 32'hC}) begin
            miscompares++;
            $display("FAIL after_reset_grant got en=%b owner=%0d addr=%h expected 1 1 c",
                     ram_en, owner, ram_addr);
        end
        tick();
        if_req    = 1'b0;
        ram_ready = 1'b0;
        #1;
        vectors++;
        if ({if_valid, if_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
            miscompares++;
            $display("FAIL after_reset_fetch got valid=%b rdata=%h expected 1 0badf00d",
                     if_valid, if_rdata);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit              busy, if_act, dm_act, cur_we;
        logic [1:0]      cur_own, exp_grant, exp_valid, exp_own, v_now;
        logic [31:0]     cur_addr, cur_wdata, exp_rdata, obs_rd;
        logic [4:0]      obs_ctl, exp_ctl;
        int unsigned     wait_cnt, lat, streak_m;
        mem_m.delete();
        do_reset();
        busy = 0; if_act = 0; dm_act = 0; cur_we = 0;
        cur_own = '0; exp_grant = '0; exp_valid = '0;
        cur_addr = '0; cur_wdata = '0; exp_rdata = '0;
        wait_cnt = 0; lat = 0; streak_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            exp_own = busy ? cur_own : 2'd0;
            obs_ctl = {ram_en, owner, if_valid, dm_valid};
            exp_ctl = {exp_grant != 2'd0, exp_own, exp_valid == 2'd1, exp_valid == 2'd2};
            vectors++;
            if (obs_ctl !== exp_ctl) begin
                miscompares++;
                $display("FAIL rand_ctl cycle %0d got %b expected %b", cyc, obs_ctl, exp_ctl);
            end
            if (busy) begin
                vectors++;
                if ({ram_we, ram_addr, ram_wdata} !== {cur_we, cur_addr, cur_wdata}) begin
                    miscompares++;
                    $display("FAIL rand_ram cycle %0d got %b %h %h expected %b %h %h", cyc,
                             ram_we, ram_addr, ram_wdata, cur_we, cur_addr, cur_wdata);
                end
            end
            if (exp_valid != 2'd0) begin
                obs_rd = (exp_valid == 2'd1) ? if_rdata : dm_rdata;
                vectors++;
                if (obs_rd !== exp_rdata) begin
                    miscompares++;
                    $display("FAIL rand_rdata cycle %0d got %h expected %h", cyc, obs_rd, exp_rdata);
                end
            end
            v_now     = exp_valid;
            exp_valid = '0;
            exp_grant = '0;

            // Requesters: hold fields while waiting, may reissue in their valid cycle.
            if (v_now == 2'd1 || !if_act) begin
                if_act  = ($urandom_range(0, 99) < ((v_now == 2'd1) ? 60 : 35));
                if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (v_now == 2'd2 || !dm_act) begin
                dm_act   = ($urandom_range(0, 99) < ((v_now == 2'd2) ? 60 : 35));
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = 32'($urandom_range(0, 15)) << 2;
                dm_wdata = $urandom;
            end
            if_req = if_act;
            dm_req = dm_act;

            if (busy) begin
                if (wait_cnt == lat) begin
                    ram_ready = 1'b1;
                    if (cur_we) begin
                        ram_rdata       = $urandom;
                        mem_m[cur_addr] = cur_wdata;
                        exp_rdata       = '0;
                    end else begin
                        ram_rdata = mem_rd(cur_addr);
                        exp_rdata = ram_rdata;
                    end
                    exp_valid = cur_own;
                    busy      = 0;
                end else begin
                    ram_ready = 1'b0;
                    ram_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                ram_ready = 1'($urandom_range(0, 1));
                ram_rdata = $urandom;
                if (dm_act && !(if_act && streak_m == MAX_DM_STREAK)) begin
                    exp_grant = 2'd2;
                    streak_m  = if_act ? streak_m + 1 : 0;
                    cur_we    = dm_we;
                    cur_addr  = dm_addr;
                    cur_wdata = dm_wdata;
                end else if (if_act) begin
                    exp_grant = 2'd1;
                    streak_m  = 0;
                    cur_we    = 1'b0;
                    cur_addr  = if_addr;
                    cur_wdata = '0;
                end
                if (exp_grant != 2'd0) begin
                    busy     = 1;
                    cur_own  = exp_grant;
                    wait_cnt = 0;
                    lat      = $urandom_range(0, 3);
                end
            end
            #1;
            vectors++;
            if ({if_stall, dm_stall} !== {if_act && v_now != 2'd1, dm_act && v_now != 2'd2}) begin
                miscompares++;
                $display("FAIL rand_stall cycle %0d got %b%b", cyc, if_stall, dm_stall);
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_store();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion expected $finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified instruction/data RAM between two requesters in the 5-stage MIPS32 pipeline: the IF-stage fetch (read only) and the MEM-stage load/store (read/write).
- Arbitrates between the two, sequences each RAM transaction, generates per-requester stall/valid, and enforces an IF anti-starvation limit and a RAM response timeout.
- Sits between the pipeline stages (alongside the hazard unit, feeding `pc_write`/`if_id_write` gating) and the RAM model.

Parameters:
- MAX_DM_STREAK, 2: max consecutive DM grants while IF is waiting; legal range >= 1.
- TIMEOUT, 16: cycles in WAIT without `ram_ready` before forced completion; legal range >= 2.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_valid  out  1  one-cycle pulse: fetch complete
- if_rdata  out  32  fetched word; valid while if_valid=1
- if_stall  out  1  if_req & ~if_valid (combinational)
- dm_req  in  1  data request
- dm_we  in  1  1=store, 0=load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_valid  out  1  one-cycle pulse: data access complete
- dm_rdata  out  32  load data; 0 for stores and timeouts
- dm_stall  out  1  dm_req & ~dm_valid (combinational)
- ram_en  out  1  one-cycle transaction start strobe
- ram_we  out  1  write enable, qualified by ram_en
- ram_addr  out  32  RAM address, held for the whole transaction
- ram_wdata  out  32  RAM write data, held for the whole transaction
- ram_rdata  in  32  RAM read data, sampled when ram_ready=1
- ram_ready  in  1  RAM completion, may assert in the same cycle as ram_en
- owner  out  2  0=none, 1=IF, 2=DM (debug)
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- States: IDLE, WAIT_IF, WAIT_DM.
- Reset (synchronous): state=IDLE. All outputs 0, including ram_addr, ram_wdata, if_rdata, dm_rdata and timeout_err. streak counter=0, timeout counter=0.
- IDLE grant decision, taken on a rising edge:
  - dm_req=1 and not (if_req=1 and streak==MAX_DM_STREAK) -> grant DM.
  - else if_req=1 -> grant IF.
  - else stay in IDLE.
- On grant:
  - Register ram_en=1, ram_we=dm_we (0 for IF), ram_addr, and ram_wdata (0 for IF).
  - Set owner and move to WAIT_x.
  - Timeout counter=0.
- Streak counter:
  - DM grant with if_req=1: streak+1, saturating at MAX_DM_STREAK.
  - DM grant with if_req=0: streak=0.
  - IF grant: streak=0.
- WAIT_x:
  - ram_en=0 after its first cycle.
  - ram_addr and ram_wdata stay stable.
  - Timeout counter increments every cycle.
- Completion:
  - ram_ready=1 sampled in WAIT_x -> next cycle x_valid=1 for exactly one cycle.
  - x_rdata=ram_rdata (dm_rdata=0 if the access was a store).
  - state=IDLE, owner=0.
- Timeout:
  - Counter reaches TIMEOUT with no ram_ready -> same completion path.
  - x_rdata=0, timeout_err=1.
- Latency: request sampled at edge 0, ram_en high in cycle 1, ready sampled earliest at edge 1 -> valid high in cycle 2. Minimum is 2 cycles per transaction.
- Requester rule:
  - Requester holds req, addr, we and wdata stable until it sees valid.
  - In the valid cycle it may keep req high with new fields. The arbiter samples this as a new request at that edge, giving back-to-back issue with no idle cycle.
- Ignored inputs:
  - ram_ready while in IDLE is ignored.
  - Request deassertion while in WAIT is ignored: the transaction completes and valid still pulses.
- Reset mid-transaction: abandon the transaction, no valid pulse. A late ram_ready arrives in IDLE and is ignored.
- if_valid and dm_valid are never high in the same cycle.
- Simultaneous if_req and dm_req with streak < MAX_DM_STREAK: DM wins.

Test Plan:
- Single fetch, reset released: if_req=1, if_addr=0x4, ram_ready 2 cycles after ram_en with ram_rdata=0x20080005.
  - ram_en pulse at cycle 1 with ram_addr=0x4.
  - if_valid pulse at cycle 4 with if_rdata=0x20080005.
  - if_stall high for cycles 0-3.
- Collision: if_req and dm_req (load, 0x100) both rise in the same cycle, ram_ready=1 immediately.
  - DM served first (dm_valid at cycle 2).
  - IF served second (if_valid at cycle 4).
- Starvation, MAX_DM_STREAK=2: dm_req and if_req held high continuously, ram_ready tied to 1.
  - Grant order DM, DM, IF, DM, DM, IF.
  - owner sequence 2,2,1,2,2,1.
- Store: dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF.
  - ram_en=1 with ram_we=1, ram_addr=0x10, ram_wdata=0xDEADBEEF.
  - dm_valid pulses with dm_rdata=0.
- Timeout, TIMEOUT=8, ram_ready held 0: dm load request.
  - dm_valid pulses with dm_rdata=0.
  - timeout_err=1 and remains 1 across later successful transactions until reset.
- Reset in WAIT_IF, then ram_ready=1 one cycle after reset.
  - All outputs 0 and state IDLE.
  - No if_valid pulse.
  - Next if_req is serviced normally.
